// File: rtl/elementwise_division_if.sv
// Vector handshake bundle for the elementwise divider: operand channel in,
// result channel out.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both high. The producer may raise valid at any time.
// The consumer may raise ready at any time. Payload is only meaningful while
// valid is high.
interface elementwise_division_if #(
  parameter int N = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N-1:0][2*N-1:0]    dividend;
  logic [N-1:0][N-1:0]      divisor;
  logic                     out_valid;
  logic                     out_ready;
  logic [N-1:0][2*N-1:0]    quotient;
  logic [N-1:0][N-1:0]      remainder;
  logic [N-1:0]             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/elementwise_division.sv
// N-lane radix-2 restoring divider: each lane divides a 2N-bit dividend by an
// N-bit divisor, one quotient bit per cycle, and all lanes run in lockstep.
module elementwise_division #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  elementwise_division_if.slave  bus,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int              CW   = $clog2(2*N);
  localparam logic [CW-1:0]   LAST = CW'(2*N-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  // The dividend register doubles as the quotient: quotient bits shift in at the LSB
  logic [N-1:0][2*N-1:0]   dvd_q, dvd_d;
  logic [N-1:0][N-1:0]     dsr_q, dsr_d;
  logic [N-1:0][N-1:0]     rem_q, rem_d;
  logic [N-1:0][2*N-1:0]   quo_q, quo_d;
  logic [N-1:0][N-1:0]     rmd_q, rmd_d;
  logic [N-1:0]            dbz_q, dbz_d;

  logic [N-1:0][N:0]       trial;
  logic [N-1:0][N:0]       diff;
  logic [N-1:0]            ge;
  logic [N-1:0][2*N-1:0]   step_dvd;
  logic [N-1:0][N-1:0]     step_rem;

  logic accept;
  logic last_step;

  assign accept    = (state_q == S_IDLE) && bus.in_valid;
  assign last_step = (state_q == S_BUSY) && (cnt_q == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid)  state_d = S_BUSY;
      S_BUSY: if (cnt_q == LAST) state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready    = (state_q == S_IDLE);
    bus.out_valid   = (state_q == S_DONE);
    busy            = (state_q == S_BUSY);
    dbg_state       = state_q;
    bus.quotient    = quo_q;
    bus.remainder   = rmd_q;
    bus.div_by_zero = dbz_q;
  end

  // One restoring step per lane. The partial remainder stays below the divisor,
  // so the N+1-bit trial value always reduces back into N bits.
  always_comb begin
    trial    = '0;
    diff     = '0;
    ge       = '0;
    step_dvd = dvd_q;
    step_rem = rem_q;
    for (int i = 0; i < N; i++) begin
      trial[i]    = {rem_q[i], dvd_q[i][2*N-1]};
      diff[i]     = trial[i] - {1'b0, dsr_q[i]};
      ge[i]       = (trial[i] >= {1'b0, dsr_q[i]});
      step_rem[i] = ge[i] ? diff[i][N-1:0] : trial[i][N-1:0];
      step_dvd[i] = {dvd_q[i][2*N-2:0], ge[i]};
    end
  end

  // With a zero divisor every trial subtraction succeeds, so the remainder
  // naturally ends up as the low N dividend bits; only the quotient is forced.
  always_comb begin
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dsr_d = dsr_q;
    rem_d = rem_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    dbz_d = dbz_q;
    if (accept) begin
      dvd_d = bus.dividend;
      dsr_d = bus.divisor;
      rem_d = '0;
      cnt_d = '0;
    end else if (state_q == S_BUSY) begin
      dvd_d = step_dvd;
      rem_d = step_rem;
      cnt_d = cnt_q + CW'(1);
      if (last_step) begin
        for (int i = 0; i < N; i++) begin
          dbz_d[i] = (dsr_q[i] == '0);
          quo_d[i] = (dsr_q[i] == '0) ? {(2*N){1'b1}} : step_dvd[i];
          rmd_d[i] = step_rem[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dvd_q <= '0;
      dsr_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      dbz_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      dbz_q <= dbz_d;
    end
  end

endmodule

// File: tb/tb_elementwise_division.sv
// Randomized self-checking bench for elementwise_division (N=8): integer
// division reference model, handshake timing, backpressure and reset abort.
module tb_elementwise_division;

  localparam int N  = 8;
  localparam int EW = N*2*N + N*N + N;

  typedef logic [N-1:0][2*N-1:0] dvd_vec_t;
  typedef logic [N-1:0][N-1:0]   dsr_vec_t;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];

  elementwise_division_if #(.N(N)) bus ();

  elementwise_division #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer division per lane
  function automatic logic [EW-1:0] model(input dvd_vec_t a, input dsr_vec_t b);
    dvd_vec_t       q;
    dsr_vec_t       r;
    logic [N-1:0]   z;
    logic [2*N-1:0] rr;
    for (int i = 0; i < N; i++) begin
      if (b[i] == 0) begin
        q[i] = {(2*N){1'b1}};
        r[i] = a[i][N-1:0];
        z[i] = 1'b1;
      end else begin
        q[i] = a[i] / {{N{1'b0}}, b[i]};
        rr   = a[i] % {{N{1'b0}}, b[i]};
        r[i] = rr[N-1:0];
        z[i] = 1'b0;
      end
    end
    return {q, r, z};
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) begin
      bus.dividend[i] = (2*N)'($urandom_range(0, 65535));
      bus.divisor[i]  = N'($urandom_range(0, 255));
    end
  endtask

  task automatic check_outputs(input logic [EW-1:0] e);
    dvd_vec_t     eq;
    dsr_vec_t     er;
    logic [N-1:0] ez;
    {eq, er, ez} = e;
    for (int i = 0; i < N; i++) begin
      check($sformatf("quotient[%0d]", i), bus.quotient[i], eq[i]);
      check($sformatf("remainder[%0d]", i), bus.remainder[i], er[i]);
    end
    check("div_by_zero", bus.div_by_zero, ez);
  endtask

  // Driver: present one vector pair in IDLE and let it be accepted
  task automatic start_job(input dvd_vec_t a, input dsr_vec_t b);
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
    check("accept_busy", busy, 1);
    check("accept_in_ready", bus.in_ready, 0);
  endtask

  // Wait for the result, compare, optionally hold off out_ready, then drain
  task automatic finish_job(input int hold);
    logic [EW-1:0] e;
    int            k;
    bit            bad;
    e   = exp_q.pop_front();
    k   = 0;
    bad = 1'b0;
    while (!bus.out_valid && k < 40) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      scramble_inputs();
      @(posedge clk);
      #1;
      k++;
      if (!bus.out_valid && (bus.in_ready || !busy)) bad = 1'b1;
    end
    check("latency", 64'(k), 16);
    check("busy_window", 64'(bad), 0);
    check("done_busy", busy, 0);
    check("done_in_ready", bus.in_ready, 0);
    check_outputs(e);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        bus.in_valid = 1'b1;
        scramble_inputs();
        @(posedge clk);
        #1;
      end
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check_outputs(e);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("drain_out_valid", bus.out_valid, 0);
    check("drain_in_ready", bus.in_ready, 1);
    check_outputs(e);
  endtask

  task automatic run_job(input dvd_vec_t a, input dsr_vec_t b, input int hold);
    exp_q.push_back(model(a, b));
    start_job(a, b);
    finish_job(hold);
  endtask

  initial begin
    dvd_vec_t a;
    dsr_vec_t b;
    dsr_vec_t ra;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quotient", 64'(bus.quotient[0]), 0);
    check("rst_remainder", 64'(bus.remainder[0]), 0);
    check("rst_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer lanes
    for (int i = 0; i < N; i++) begin
      a[i] = (2*N)'($urandom_range(0, 65535));
      b[i] = N'($urandom_range(1, 255));
    end
    a[0] = 16'd2600;  b[0] = 8'd13;
    a[1] = 16'd65535; b[1] = 8'd1;
    a[2] = 16'd1000;  b[2] = 8'd7;
    a[3] = 16'd0;     b[3] = 8'd5;
    run_job(a, b, 0);
    check("kat_q0", bus.quotient[0], 200);
    check("kat_q1", bus.quotient[1], 65535);
    check("kat_q2", bus.quotient[2], 142);
    check("kat_q3", bus.quotient[3], 0);
    check("kat_r2", bus.remainder[2], 6);
    check("kat_r0", bus.remainder[0], 0);
    check("kat_dbz", bus.div_by_zero, 0);

    // Zero divisor on lane 3 with backpressure in DONE
    for (int i = 0; i < N; i++) begin
      a[i] = (2*N)'($urandom_range(0, 65535));
      b[i] = N'($urandom_range(1, 255));
    end
    a[3] = 16'h1234; b[3] = 8'h00;
    run_job(a, b, 5);
    check("dbz_q3", bus.quotient[3], 16'hFFFF);
    check("dbz_r3", bus.remainder[3], 8'h34);
    check("dbz_flags", bus.div_by_zero, 8'b0000_1000);

    // Reset in the middle of a job aborts it
    for (int i = 0; i < N; i++) begin
      a[i] = (2*N)'($urandom_range(0, 65535));
      b[i] = N'($urandom_range(1, 255));
    end
    start_job(a, b);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_quotient", 64'(bus.quotient[3]), 0);
    check("abort_remainder", 64'(bus.remainder[3]), 0);
    check("abort_dbz", bus.div_by_zero, 0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      a[i] = (2*N)'($urandom_range(0, 65535));
      b[i] = N'($urandom_range(1, 255));
    end
    run_job(a, b, 1);

    // Round trip: products of a*b divided by b recover a exactly
    for (int j = 0; j < 13; j++) begin
      for (int i = 0; i < N; i++) begin
        ra[i] = N'($urandom_range(0, 255));
        b[i]  = N'($urandom_range(1, 255));
        a[i]  = {{N{1'b0}}, ra[i]} * {{N{1'b0}}, b[i]};
      end
      run_job(a, b, 0);
      for (int i = 0; i < N; i++) begin
        check($sformatf("rt_q[%0d]", i), bus.quotient[i], ra[i]);
        check($sformatf("rt_r[%0d]", i), bus.remainder[i], 0);
      end
    end

    // Random vectors with occasional zero divisors and random backpressure
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = (2*N)'($urandom_range(0, 65535));
        if ($urandom_range(0, 7) == 0)      b[i] = '0;
        else if ($urandom_range(0, 1) == 0) b[i] = N'($urandom_range(1, 15));
        else                                b[i] = N'($urandom_range(1, 255));
      end
      run_job(a, b, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
